// File: rtl/param_acc_processor_pkg.sv
// Shared definitions for the parametrised accumulator processor:
// opcodes, state encodings and the word-width rule.
package param_acc_processor_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    localparam logic [4:0] S_FETCH  = 5'd0;
    localparam logic [4:0] S_DECODE = 5'd1;
    localparam logic [4:0] S_LOAD   = 5'd2;
    localparam logic [4:0] S_EXEC   = 5'd3;
    localparam logic [4:0] S_STORE  = 5'd4;
    localparam logic [4:0] S_HALT   = 5'd5;

    // An instruction word must hold the opcode above a full operand address.
    localparam int OPCODE_W = 3;

    function automatic bit widths_ok(input int data_w, input int addr_w);
        return data_w >= addr_w + OPCODE_W;
    endfunction

endpackage

// File: rtl/param_acc_processor_alu.sv
// Combinational EXEC arithmetic: LDA pass-through, ADD with carry-out,
// SUB with unsigned borrow, AND. Other opcodes return the accumulator.
module acc_alu
    import param_acc_processor_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry
);

    logic [DATA_W:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    // NOTE: outputs get a default first so no latch is inferred.
    always_comb begin
        o_result = i_a;
        o_carry  = 1'b0;
        case (i_op)
            OP_LDA: o_result = i_b;
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_result = i_a - i_b;
                o_carry  = (i_a < i_b);
            end
            OP_AND: o_result = i_a & i_b;
            default: o_result = i_a;
        endcase
    end

endmodule

// File: rtl/param_acc_processor.sv
// Multicycle accumulator processor with generic widths and an external
// variable-latency req/ack memory port; one access per state visit.
module param_acc_processor
    import param_acc_processor_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ACK,
    output logic              HALTED,
    output logic              CARRY,
    output logic [4:0]        STATE,
    output logic [2:0]        OPCODE,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] AC,
    output logic [ADDR_W-1:0] MA,
    output logic [DATA_W-1:0] MD
);

    if (!widths_ok(DATA_W, ADDR_W)) begin : g_width_check
        $error("DATA_W must be at least ADDR_W + %0d", OPCODE_W);
    end

    logic [4:0]        r_state;
    logic [4:0]        w_next_state;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ac;
    logic [ADDR_W-1:0] r_ma;
    logic [DATA_W-1:0] r_md;
    logic              r_carry;

    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_halted;
    logic [2:0]        w_opcode;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_carry;

    assign w_opcode = r_ir[DATA_W-1 -: 3];
    assign w_addr   = r_ir[ADDR_W-1:0];

    acc_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_opcode),
        .i_a      (r_ac),
        .i_b      (r_md),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  if (MEM_ACK) w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_HLT:         w_next_state = S_HALT;
                    OP_JMP, OP_JZ:  w_next_state = S_FETCH;
                    OP_STA:         w_next_state = S_STORE;
                    default:        w_next_state = S_LOAD;
                endcase
            end
            S_LOAD:   if (MEM_ACK) w_next_state = S_EXEC;
            S_EXEC:   w_next_state = S_FETCH;
            S_STORE:  if (MEM_ACK) w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_STORE);
        w_mem_we  = (r_state == S_STORE);
        w_halted  = (r_state == S_HALT);
    end

    // MA is re-pointed at PC whenever control returns to FETCH.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ir    <= '0;
            r_pc    <= RESET_PC;
            r_ac    <= '0;
            r_ma    <= RESET_PC;
            r_md    <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (MEM_ACK) begin
                        r_ir <= MEM_RDATA;
                        r_md <= MEM_RDATA;
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    case (w_opcode)
                        OP_HLT: ;
                        OP_JMP: begin
                            r_pc <= w_addr;
                            r_ma <= w_addr;
                        end
                        OP_JZ: begin
                            if (r_ac == '0) begin
                                r_pc <= w_addr;
                                r_ma <= w_addr;
                            end else begin
                                r_ma <= r_pc;
                            end
                        end
                        OP_STA: begin
                            r_ma <= w_addr;
                            r_md <= r_ac;
                        end
                        default: r_ma <= w_addr;
                    endcase
                end
                S_LOAD: begin
                    if (MEM_ACK) r_md <= MEM_RDATA;
                end
                S_EXEC: begin
                    r_ac <= w_alu_result;
                    if (w_opcode == OP_ADD || w_opcode == OP_SUB) r_carry <= w_alu_carry;
                    r_ma <= r_pc;
                end
                S_STORE: begin
                    if (MEM_ACK) r_ma <= r_pc;
                end
                S_HALT: ;
                default: r_ma <= r_pc;
            endcase
        end
    end

    assign MEM_REQ   = w_mem_req;
    assign MEM_WE    = w_mem_we;
    assign MEM_ADDR  = r_ma;
    assign MEM_WDATA = r_md;
    assign HALTED    = w_halted;
    assign CARRY     = r_carry;
    assign STATE     = r_state;
    assign OPCODE    = w_opcode;
    assign IR        = r_ir;
    assign PC        = r_pc;
    assign AC        = r_ac;
    assign MA        = r_ma;
    assign MD        = r_md;

endmodule

// File: tb/tb_param_acc_processor.sv
// Bench for param_acc_processor: an instruction-level model checks every
// retired instruction of the default-width core; directed programs pin it.
module tb_param_acc_processor;
    import param_acc_processor_pkg::*;

    localparam int DW = 16;
    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  = 1'b0;
    logic rst2 = 1'b0;

    // default-width core
    logic          mem_req, mem_we, halted, carry;
    logic          mem_ack = 1'b0;
    logic [AW-1:0] mem_addr, pc, ma;
    logic [DW-1:0] wdata, ir, ac, md;
    logic [DW-1:0] rdata = '0;
    logic [4:0]    state;
    logic [2:0]    opcode;

    // RESET_PC = 0xFFF core
    logic          q_req, q_we, q_halted, q_carry;
    logic          q_ack = 1'b0;
    logic [AW-1:0] q_addr, q_pc, q_ma;
    logic [DW-1:0] q_wdata, q_ir, q_ac, q_md;
    logic [DW-1:0] q_rdata = '0;
    logic [4:0]    q_state;
    logic [2:0]    q_opcode;

    // 24/16 core
    logic          x_req, x_we, x_halted, x_carry;
    logic          x_ack = 1'b0;
    logic [15:0]   x_addr, x_pc, x_ma;
    logic [23:0]   x_wdata, x_ir, x_ac, x_md;
    logic [23:0]   x_rdata = '0;
    logic [4:0]    x_state;
    logic [2:0]    x_opcode;

    param_acc_processor dut (
        .CLK(clk), .RESET(rst), .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
        .MEM_WDATA(wdata), .MEM_RDATA(rdata), .MEM_ACK(mem_ack), .HALTED(halted),
        .CARRY(carry), .STATE(state), .OPCODE(opcode), .IR(ir), .PC(pc), .AC(ac),
        .MA(ma), .MD(md)
    );

    param_acc_processor #(.RESET_PC(12'hFFF)) dut_pc (
        .CLK(clk), .RESET(rst2), .MEM_REQ(q_req), .MEM_WE(q_we), .MEM_ADDR(q_addr),
        .MEM_WDATA(q_wdata), .MEM_RDATA(q_rdata), .MEM_ACK(q_ack), .HALTED(q_halted),
        .CARRY(q_carry), .STATE(q_state), .OPCODE(q_opcode), .IR(q_ir), .PC(q_pc),
        .AC(q_ac), .MA(q_ma), .MD(q_md)
    );

    param_acc_processor #(.DATA_W(24), .ADDR_W(16)) dut_w (
        .CLK(clk), .RESET(rst2), .MEM_REQ(x_req), .MEM_WE(x_we), .MEM_ADDR(x_addr),
        .MEM_WDATA(x_wdata), .MEM_RDATA(x_rdata), .MEM_ACK(x_ack), .HALTED(x_halted),
        .CARRY(x_carry), .STATE(x_state), .OPCODE(x_opcode), .IR(x_ir), .PC(x_pc),
        .AC(x_ac), .MA(x_ma), .MD(x_md)
    );

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];
    logic [DW-1:0] mem_q   [0:4095];
    logic [23:0]   mem_x   [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Main memory: ACK in the (wait_n+1)-th cycle of each request; also
    // verifies the request stays frozen across wait cycles.
    int            wait_n = 0;
    int            cnt    = 0;
    logic          h_req  = 1'b0;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            mem_ack = 1'b0;
            cnt     = 0;
            h_req   = 1'b0;
        end else begin
            if (h_req && !mem_ack) begin
                check("hold_req",   mem_req,  1'b1);
                check("hold_addr",  mem_addr, h_addr);
                check("hold_we",    mem_we,   h_we);
                check("hold_wdata", wdata,    h_wdata);
            end
            if (!mem_req) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else begin
                if (mem_ack) cnt = 0;
                mem_ack = (cnt == wait_n);
                if (mem_ack) begin
                    if (mem_we) mem[mem_addr] = wdata;
                    else        rdata = mem[mem_addr];
                end
                cnt++;
            end
            h_req   = mem_req;
            h_we    = mem_we;
            h_addr  = mem_addr;
            h_wdata = wdata;
        end
    end

    always @(negedge clk or posedge rst2) begin
        if (rst2) begin
            q_ack = 1'b0;
            x_ack = 1'b0;
        end else begin
            q_ack = q_req;
            if (q_req) begin
                if (q_we) mem_q[q_addr] = q_wdata;
                else      q_rdata = mem_q[q_addr];
            end
            x_ack = x_req;
            if (x_req) begin
                if (x_we) mem_x[x_addr] = x_wdata;
                else      x_rdata = mem_x[x_addr];
            end
        end
    end

    // Instruction-level model of the default core.
    int edges = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ac, m_md, m_instr;
    logic          m_c;
    logic [4:0]    prev_state;
    int            last_edges;
    logic [AW-1:0] m_a;
    logic [2:0]    m_op;
    int            m_sum, exp_cyc;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_pc       = '0;
            m_ac       = '0;
            m_md       = '0;
            m_c        = 1'b0;
            prev_state = S_FETCH;
            last_edges = 0;
        end else begin
            if (state != prev_state && (state == S_FETCH || state == S_HALT)) begin
                m_instr = ref_mem[m_pc];
                m_op    = m_instr[DW-1 -: 3];
                m_a     = m_instr[AW-1:0];
                m_pc    = m_pc + 12'd1;
                m_md    = m_instr;
                exp_cyc = 2 + wait_n;
                case (m_op)
                    OP_LDA: begin
                        m_md = ref_mem[m_a]; m_ac = m_md; exp_cyc = 4 + 2 * wait_n;
                    end
                    OP_ADD: begin
                        m_md  = ref_mem[m_a];
                        m_sum = int'(m_ac) + int'(m_md);
                        m_c   = (m_sum > 65535);
                        m_ac  = m_sum[15:0];
                        exp_cyc = 4 + 2 * wait_n;
                    end
                    OP_SUB: begin
                        m_md = ref_mem[m_a]; m_c = (m_ac < m_md); m_ac = m_ac - m_md;
                        exp_cyc = 4 + 2 * wait_n;
                    end
                    OP_AND: begin
                        m_md = ref_mem[m_a]; m_ac = m_ac & m_md; exp_cyc = 4 + 2 * wait_n;
                    end
                    OP_STA: begin
                        ref_mem[m_a] = m_ac; m_md = m_ac; exp_cyc = 3 + 2 * wait_n;
                    end
                    OP_JMP: m_pc = m_a;
                    OP_JZ:  if (m_ac == '0) m_pc = m_a;
                    default: ;
                endcase
                check("m_state", state, (m_op == OP_HLT) ? S_HALT : S_FETCH);
                check("m_pc",    pc,    m_pc);
                check("m_ac",    ac,    m_ac);
                check("m_carry", carry, m_c);
                check("m_ir",    ir,    m_instr);
                check("m_opcode", opcode, m_op);
                check("m_md",    md,    m_md);
                check("m_wdata", wdata, m_md);
                check("m_cycles", edges - last_edges, exp_cyc);
                check("m_halted", halted, (m_op == OP_HLT));
                check("m_req",   mem_req, (m_op != OP_HLT));
                check("m_we",    mem_we, 1'b0);
                if (m_op == OP_HLT) check("m_ma_halt", ma, m_pc - 12'd1);
                else                check("m_ma", mem_addr, m_pc);
                if (m_op == OP_STA) check("m_stored", mem[m_a], m_ac);
                last_edges = edges;
            end
            prev_state = state;
        end
    end

    task automatic load(input int addr, input logic [DW-1:0] val);
        mem[addr]     = val;
        ref_mem[addr] = val;
    endtask

    task automatic clear_main();
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    endtask

    task automatic release_main();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_fetch(input logic [AW-1:0] target, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (state == S_FETCH && pc == target) found = 1'b1;
        end
        check(name, found, 1'b1);
    endtask

    task automatic check_halt_at(input int cycles, input string name);
        repeat (cycles - 1) @(posedge clk);
        #1 check({name, "_not_yet"}, halted, 1'b0);
        @(posedge clk);
        #1 check(name, halted, 1'b1);
    endtask

    task automatic load_prog2();
        clear_main();
        load(0, 16'h2100); load(1, 16'h6101); load(2, 16'h4102); load(3, 16'h0000);
        load(12'h100, 16'd5); load(12'h101, 16'd7);
    endtask

    initial begin
        bit found;
        load_prog2();
        for (int i = 0; i < 4096; i++) mem_q[i] = '0;
        for (int i = 0; i < 65536; i++) mem_x[i] = '0;

        // asynchronous reset, no clock edge yet
        #1 rst = 1'b1; rst2 = 1'b1;
        #1;
        check("rst_state", state, S_FETCH);
        check("rst_pc", pc, 12'h000);
        check("rst_ma", ma, 12'h000);
        check("rst_ir", ir, 16'h0000);
        check("rst_ac", ac, 16'h0000);
        check("rst_md", md, 16'h0000);
        check("rst_carry", carry, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_req", mem_req, 1'b1);
        check("rst_we", mem_we, 1'b0);
        check("rst_q_pc", q_pc, 12'hFFF);
        check("rst_q_ma", q_addr, 12'hFFF);

        // program 2, zero wait states
        wait_n = 0;
        release_main();
        check_halt_at(13, "p2_halt13");
        check("p2_result", mem[12'h102], 16'h000C);
        check("p2_pc", pc, 12'h004);
        check("p2_ac", ac, 16'h000C);
        check("p2_carry", carry, 1'b0);

        // program 2, three wait states; reset dropped into the first LOAD wait
        #1 rst = 1'b1;
        load_prog2();
        wait_n = 3;
        release_main();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (state == S_LOAD) found = 1'b1;
        end
        check("reach_load", found, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_state", state, S_FETCH);
        check("mid_pc", pc, 12'h000);
        check("mid_addr", mem_addr, 12'h000);
        check("mid_ac", ac, 16'h0000);
        check("mid_req", mem_req, 1'b1);
        check("mid_we", mem_we, 1'b0);
        release_main();
        #6 check("restart_addr", mem_addr, 12'h000);
        check_halt_at(34, "p2w_halt34");
        check("p2w_result", mem[12'h102], 16'h000C);
        check("p2w_pc", pc, 12'h004);

        // carry, borrow, AND, branches; one wait state
        #1 rst = 1'b1;
        clear_main();
        wait_n = 1;
        load(12'h000, 16'h2100); load(12'h001, 16'h6101);
        load(12'h002, 16'h2102); load(12'h003, 16'h8103);
        load(12'h004, 16'h2104); load(12'h005, 16'hA105);
        load(12'h006, 16'h2106); load(12'h007, 16'hE020);
        load(12'h008, 16'h8106); load(12'h009, 16'hE010);
        load(12'h010, 16'h4110); load(12'h011, 16'hC030);
        load(12'h030, 16'h6107); load(12'h031, 16'h6107); load(12'h032, 16'h0000);
        load(12'h100, 16'hFFFF); load(12'h101, 16'h0001); load(12'h102, 16'h0003);
        load(12'h103, 16'h0005); load(12'h104, 16'h00FF); load(12'h105, 16'h0F0F);
        load(12'h106, 16'h0001); load(12'h107, 16'h8000); load(12'h110, 16'hBEEF);
        release_main();
        wait_fetch(12'h002, "reach_add");
        check("add_ac", ac, 16'h0000);
        check("add_carry", carry, 1'b1);
        wait_fetch(12'h004, "reach_sub");
        check("sub_ac", ac, 16'hFFFE);
        check("sub_borrow", carry, 1'b1);
        wait_fetch(12'h006, "reach_and");
        check("and_ac", ac, 16'h000F);
        check("and_carry_kept", carry, 1'b1);
        wait_fetch(12'h008, "reach_jz_fall");
        check("jz_fall_addr", mem_addr, 12'h008);
        wait_fetch(12'h010, "reach_jz_taken");
        check("jz_taken_addr", mem_addr, 12'h010);
        check("sub_eq_carry", carry, 1'b0);
        wait_fetch(12'h031, "reach_add2");
        check("add2_ac", ac, 16'h8000);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (halted) found = 1'b1;
        end
        check("br_halted", found, 1'b1);
        check("br_pc", pc, 12'h033);
        check("br_ac", ac, 16'h0000);
        check("br_carry", carry, 1'b1);
        check("br_store", mem[12'h110], 16'h0000);

        // PC wrap from RESET_PC=0xFFF and 24-bit datapath
        mem_q[12'hFFF] = 16'h2100;
        mem_q[12'h100] = 16'h1234;
        mem_x[0] = 24'h200100; mem_x[1] = 24'h600101; mem_x[2] = 24'h400102;
        mem_x[3] = 24'h000000; mem_x[16'h100] = 24'd5; mem_x[16'h101] = 24'd7;
        @(posedge clk);
        #2 rst2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (q_state == S_FETCH && q_pc == 12'h000) found = 1'b1;
        end
        check("wrap_fetch0", found, 1'b1);
        check("wrap_addr", q_addr, 12'h000);
        check("wrap_ac", q_ac, 16'h1234);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (q_halted && x_halted) found = 1'b1;
        end
        check("aux_halted", found, 1'b1);
        check("wrap_pc_halt", q_pc, 12'h001);
        check("w24_result", mem_x[16'h102], 24'h00000C);
        check("w24_ac", x_ac, 24'h00000C);
        check("w24_pc", x_pc, 16'h0004);
        check("w24_carry", x_carry, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
